// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet header insertion path.
package eth_pkg;

   localparam int unsigned ETH_HDR_BYTES  = 14;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR1,
      ST_HDR2,
      ST_DATA,
      ST_TAIL
   } state_t;

   function automatic logic [2:0] keep2cnt(input logic [3:0] keep);
      keep2cnt = 3'(keep[3]) + 3'(keep[2]) + 3'(keep[1]) + 3'(keep[0]);
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-beat AXI-Stream output register; loads only when empty or being drained.
module axis_out_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] d_data,
   input  logic [3:0]  d_keep,
   input  logic        d_last,
   output logic        free,
   output logic [31:0] m_tdata,
   output logic [3:0]  m_tkeep,
   output logic        m_tlast,
   output logic        m_tvalid,
   input  logic        m_tready
);

   assign free = !m_tvalid | m_tready;

   always_ff @(posedge clk) begin
      if (reset) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tkeep  <= '0;
         m_tlast  <= 1'b0;
      end else if (free) begin
         m_tvalid <= load;
         if (load) begin
            m_tdata <= d_data;
            m_tkeep <= d_keep;
            m_tlast <= d_last;
         end
      end
   end

endmodule

// File: rtl/eth_header_inserter.sv
// Prepends the 14-byte Ethernet II header to an IPv4 packet stream,
// shifting every payload byte by two lanes behind the header.
module eth_header_inserter
   import eth_pkg::*;
#(
   parameter logic [15:0] ETHERTYPE = ETHERTYPE_IPV4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [47:0] mac_dest,
   input  logic [47:0] mac_src,
   input  logic [31:0] s_tdata,
   input  logic [3:0]  s_tkeep,
   input  logic        s_tlast,
   input  logic        s_tvalid,
   output logic        s_tready,
   output logic [31:0] m_tdata,
   output logic [3:0]  m_tkeep,
   output logic        m_tlast,
   output logic        m_tvalid,
   input  logic        m_tready
);

   state_t      state, state_nxt;
   logic        free;
   logic        load;
   logic [31:0] ld_data;
   logic [3:0]  ld_keep;
   logic        ld_last;
   logic [15:0] dest_lo;
   logic [47:0] src_q;
   logic [15:0] residue;
   logic [1:0]  res_keep;
   logic        accept;
   logic        short_last;

   assign accept     = s_tvalid & s_tready;
   assign short_last = keep2cnt(s_tkeep) <= 3'd2;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (s_tvalid & free) state_nxt = ST_HDR1;
         ST_HDR1: if (free) state_nxt = ST_HDR2;
         ST_HDR2: if (free) state_nxt = ST_DATA;
         ST_DATA: if (accept & s_tlast) state_nxt = short_last ? ST_IDLE : ST_TAIL;
         ST_TAIL: if (free) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Beat 0 comes straight from the sideband; later header beats use the latched copy.
   always_comb begin
      load     = 1'b0;
      ld_data  = '0;
      ld_keep  = 4'b1111;
      ld_last  = 1'b0;
      s_tready = 1'b0;
      case (state)
         ST_IDLE: begin
            load    = s_tvalid & free;
            ld_data = mac_dest[47:16];
         end
         ST_HDR1: begin
            load    = free;
            ld_data = {dest_lo, src_q[47:32]};
         end
         ST_HDR2: begin
            load    = free;
            ld_data = src_q[31:0];
         end
         ST_DATA: begin
            s_tready = free;
            load     = accept;
            ld_data  = {residue, s_tdata[31:16]};
            if (s_tlast && short_last) begin
               ld_keep = {2'b11, s_tkeep[3:2]};
               ld_last = 1'b1;
            end
         end
         ST_TAIL: begin
            load    = free;
            ld_data = {residue, 16'h0000};
            ld_keep = {res_keep, 2'b00};
            ld_last = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dest_lo  <= '0;
         src_q    <= '0;
         residue  <= '0;
         res_keep <= '0;
      end else begin
         if (state == ST_IDLE && load) begin
            dest_lo <= mac_dest[15:0];
            src_q   <= mac_src;
         end
         if (state == ST_HDR2 && load) begin
            residue  <= ETHERTYPE;
            res_keep <= 2'b11;
         end
         if (state == ST_DATA && accept) begin
            residue <= s_tdata[15:0];
            if (s_tlast && !short_last) res_keep <= s_tkeep[1:0];
         end
      end
   end

   axis_out_reg u_out (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .d_data   (ld_data),
      .d_keep   (ld_keep),
      .d_last   (ld_last),
      .free     (free),
      .m_tdata  (m_tdata),
      .m_tkeep  (m_tkeep),
      .m_tlast  (m_tlast),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready)
   );

endmodule
